// File: rtl/uart_tx_arbiter_pkg.sv
// Shared types and helpers for the UART transmit arbiter and its round-robin picker.
// The optional burst lock (UART_ARB_LOCK_EN) needs nothing from this package.
package uart_tx_arbiter_pkg;

    localparam int unsigned UART_BYTE_W = 8;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_SEND = 2'd1,
        ST_WAIT = 2'd2
    } arb_state_t;

    // Modulo-n add for n-entry rings where a < n and b <= n
    function automatic int unsigned wrap_add(input int unsigned a,
                                             input int unsigned b,
                                             input int unsigned n);
        int unsigned s;
        s = a + b;
        return (s >= n) ? (s - n) : s;
    endfunction

endpackage

// File: rtl/uart_tx_arbiter_rr_pick.sv
// Combinational round-robin pick: first eligible request at or after ptr, wrapping.
// Reusable by any shared-resource arbiter; mask restricts eligibility (e.g. a burst lock).
module rr_pick
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned N    = 4,
    localparam int unsigned ID_W = (N > 1) ? $clog2(N) : 1
) (
    input  logic [N-1:0]    req,
    input  logic [ID_W-1:0] ptr,
    input  logic [N-1:0]    mask,
    output logic [N-1:0]    grant,
    output logic [ID_W-1:0] idx,
    output logic            found
);

    logic [N-1:0] eligible;

    always_comb begin
        eligible = req & mask;
        grant    = '0;
        idx      = '0;
        found    = 1'b0;
        for (int unsigned i = 0; i < N; i++) begin
            if (!found && eligible[wrap_add(32'(ptr), i, N)]) begin
                found = 1'b1;
                grant[wrap_add(32'(ptr), i, N)] = 1'b1;
                idx   = ID_W'(wrap_add(32'(ptr), i, N));
            end
        end
    end

endmodule

// File: rtl/uart_tx_arbiter.sv
// Round-robin scheduler sharing one UART byte serializer among NUM_REQ requesters.
// Define UART_ARB_LOCK_EN to add req_lock_i, which lets the last grantee hold the serializer.
module uart_tx_arbiter
    import uart_tx_arbiter_pkg::*;
#(
    parameter  int unsigned NUM_REQ = 4,
    localparam int unsigned ID_W    = (NUM_REQ > 1) ? $clog2(NUM_REQ) : 1
) (
    input  logic                           clk_i,
    input  logic                           rst_i,
    input  logic [NUM_REQ-1:0]             req_valid_i,
    input  logic [UART_BYTE_W*NUM_REQ-1:0] req_data_i,
    output logic [NUM_REQ-1:0]             req_ready_o,
`ifdef UART_ARB_LOCK_EN
    input  logic [NUM_REQ-1:0]             req_lock_i,
`endif
    output logic                           tx_write_o,
    output logic [UART_BYTE_W-1:0]         tx_data_o,
    input  logic                           tx_busy_i,
    output logic [ID_W-1:0]                grant_id_o,
    output logic                           idle_o
);

    arb_state_t             state;
    arb_state_t             state_nxt;
    logic [ID_W-1:0]        ptr;
    logic [ID_W-1:0]        pick_ptr;
    logic [NUM_REQ-1:0]     pick_mask;
    logic [NUM_REQ-1:0]     pick_grant;
    logic [ID_W-1:0]        pick_idx;
    logic                   pick_found;
    logic [UART_BYTE_W-1:0] pick_data;
    logic                   lock_hold;
    logic                   accept;

    // A held lock narrows eligibility to the last grantee and freezes the pointer
`ifdef UART_ARB_LOCK_EN
    assign lock_hold = req_lock_i[grant_id_o];
`else
    assign lock_hold = 1'b0;
`endif
    assign pick_mask = lock_hold ? (NUM_REQ'(1) << grant_id_o) : '1;
    assign pick_ptr  = lock_hold ? grant_id_o : ptr;

    rr_pick #(.N(NUM_REQ)) u_pick (
        .req   (req_valid_i),
        .ptr   (pick_ptr),
        .mask  (pick_mask),
        .grant (pick_grant),
        .idx   (pick_idx),
        .found (pick_found)
    );

    always_comb begin
        pick_data = '0;
        for (int i = 0; i < int'(NUM_REQ); i++) begin
            if (pick_grant[i]) begin
                pick_data = pick_data | req_data_i[i*UART_BYTE_W +: UART_BYTE_W];
            end
        end
    end

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state <= ST_IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Next state and handshake; the write strobe is a pure decode of the state register
    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        req_ready_o = '0;
        unique case (state)
            ST_IDLE: begin
                if (!tx_busy_i && pick_found) begin
                    accept      = 1'b1;
                    req_ready_o = pick_grant;
                    state_nxt   = ST_SEND;
                end
            end
            ST_SEND: state_nxt = ST_WAIT;
            ST_WAIT: begin
                if (!tx_busy_i) begin
                    state_nxt = ST_IDLE;
                end
            end
            default: state_nxt = ST_IDLE;
        endcase
    end

    assign tx_write_o = (state == ST_SEND);
    assign idle_o     = (state == ST_IDLE) && !tx_busy_i;

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ptr        <= '0;
            tx_data_o  <= '0;
            grant_id_o <= '0;
        end else if (accept) begin
            tx_data_o  <= pick_data;
            grant_id_o <= pick_idx;
            if (!lock_hold) begin
                ptr <= ID_W'(wrap_add(32'(pick_idx), 32'd1, NUM_REQ));
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Directed bench for uart_tx_arbiter behind a 4-clocks-per-baud serializer model (40-cycle frame).
// Build with UART_ARB_LOCK_EN to also exercise the burst lock.
module tb_uart_tx_arbiter;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [3:0]  req_valid = '0;
    logic [31:0] req_data = '0;
    logic [3:0]  req_ready;
    logic        tx_write;
    logic [7:0]  tx_data;
    logic        tx_busy;
    logic [1:0]  grant_id;
    logic        idle;
`ifdef UART_ARB_LOCK_EN
    logic [3:0]  req_lock = '0;
`endif

    logic        force_busy = 1'b0;
    int          ser_cnt = 0;
    int          cyc = 0;
    logic [9:0]  wr_q[$];
    int          wr_t[$];
    int          n_vec = 0;
    int          n_err = 0;

    uart_tx_arbiter dut (
        .clk_i       (clk),
        .rst_i       (rst),
        .req_valid_i (req_valid),
        .req_data_i  (req_data),
        .req_ready_o (req_ready),
`ifdef UART_ARB_LOCK_EN
        .req_lock_i  (req_lock),
`endif
        .tx_write_o  (tx_write),
        .tx_data_o   (tx_data),
        .tx_busy_i   (tx_busy),
        .grant_id_o  (grant_id),
        .idle_o      (idle)
    );

    always #5 clk = ~clk;

    // Serializer model: busy for 40 cycles starting the cycle after a write; logs each write
    always @(posedge clk) begin
        cyc <= cyc + 1;
        if (tx_write) begin
            ser_cnt <= 40;
            wr_q.push_back({grant_id, tx_data});
            wr_t.push_back(cyc);
        end else if (ser_cnt > 0) begin
            ser_cnt <= ser_cnt - 1;
        end
    end
    assign tx_busy = (ser_cnt != 0) || force_busy;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic wait_idle(input string tag);
        int n;
        n = 0;
        while (!idle && n < 200) begin
            tick();
            n++;
        end
        chk(tag, 32'(idle), 32'd1);
    endtask

    // Offer v, wait for the accept, then check the registered grant and write strobe
    task automatic xfer(input logic [3:0] v, input logic [1:0] exp_id,
                        input logic [7:0] exp_data, input string tag);
        int n;
        logic [3:0] one;
        one = 4'b0001;
        req_valid = v;
        #1;
        n = 0;
        while (req_ready == 4'b0000 && n < 200) begin
            tick();
            #1;
            n++;
        end
        chk({tag, "_ready"}, 32'(req_ready), 32'(one << exp_id));
        tick();
        req_valid = '0;
        chk({tag, "_write"}, 32'(tx_write), 32'd1);
        chk({tag, "_data"},  32'(tx_data),  32'(exp_data));
        chk({tag, "_id"},    32'(grant_id), 32'(exp_id));
    endtask

    initial begin
        int base;
        int n;
        int fair_ids[5];
        fair_ids = '{3, 0, 1, 2, 3};

        repeat (3) tick();
        rst = 1'b0;
        #1;
        chk("rst_ready", 32'(req_ready), 32'd0);
        chk("rst_write", 32'(tx_write), 32'd0);
        chk("rst_data",  32'(tx_data),  32'd0);
        chk("rst_id",    32'(grant_id), 32'd0);
        chk("rst_idle",  32'(idle),     32'd1);

        // Single byte from requester 2 (pointer 0 -> 3)
        tick();
        req_data = 32'h00A5_0000;
        xfer(4'b0100, 2'd2, 8'hA5, "single");
        tick();
        chk("single_strobe_1cyc", 32'(tx_write), 32'd0);
        chk("single_hold_data", 32'(tx_data), 32'h0000_00A5);
        wait_idle("single_idle");
        chk("single_logged", 32'(wr_q[wr_q.size()-1]), 32'({2'd2, 8'hA5}));

        // Fairness from pointer 3: grants 3,0,1,2,3, writes 43 cycles apart (pointer -> 0)
        req_data = 32'h1312_1110;
        base = wr_q.size();
        req_valid = 4'hF;
        n = 0;
        while (wr_q.size() < base + 5 && n < 400) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("fair_count", 32'(wr_q.size()), 32'(base + 5));
        if (wr_q.size() >= base + 5) begin
            for (int i = 0; i < 5; i++) begin
                chk($sformatf("fair_%0d", i), 32'(wr_q[base+i]),
                    32'({2'(fair_ids[i]), 8'(8'h10 + fair_ids[i])}));
            end
            for (int i = 0; i < 4; i++) begin
                chk($sformatf("fair_gap_%0d", i), 32'(wr_t[base+i+1] - wr_t[base+i]), 32'd43);
            end
        end
        wait_idle("fair_idle");

        // Busy gate: no ready while busy is forced high (pointer 0 -> 2)
        req_data = 32'h4433_2211;
        force_busy = 1'b1;
        req_valid = 4'b0010;
        #1;
        chk("busy_no_ready", 32'(req_ready), 32'd0);
        repeat (4) tick();
        chk("busy_still_no_ready", 32'(req_ready), 32'd0);
        chk("busy_not_idle", 32'(idle), 32'd0);
        force_busy = 1'b0;
        #1;
        chk("busy_release_ready", 32'(req_ready), 32'b0010);
        tick();
        req_valid = '0;
        chk("busy_id", 32'(grant_id), 32'd1);
        chk("busy_write", 32'(tx_write), 32'd1);
        wait_idle("busy_idle");

        // Wrap/skip: bring pointer to 3, then only requester 1 -> grant 1, pointer 2
        xfer(4'b0100, 2'd2, 8'h33, "wrap_setup");
        wait_idle("wrap_setup_idle");
        xfer(4'b0010, 2'd1, 8'h22, "wrap");
        wait_idle("wrap_idle");
        xfer(4'b1110, 2'd2, 8'h33, "wrap_ptr2");
        wait_idle("wrap_ptr2_idle");

        // Reset during bit 4 of 0x3C: next write waits for the frame to end
        req_data = 32'h0000_003C;
        xfer(4'b0001, 2'd0, 8'h3C, "mid");
        repeat (21) tick();
        rst = 1'b1;
        #1;
        chk("mid_rst_data",  32'(tx_data),  32'd0);
        chk("mid_rst_id",    32'(grant_id), 32'd0);
        chk("mid_rst_write", 32'(tx_write), 32'd0);
        tick();
        tick();
        rst = 1'b0;
        base = wr_q.size();
        req_data = 32'h0000_C300;
        req_valid = 4'b0010;
        #1;
        chk("mid_busy_no_ready", 32'(req_ready), 32'd0);
        xfer(4'b0010, 2'd1, 8'hC3, "mid_next");
        wait_idle("mid_idle");
        chk("mid_one_write", 32'(wr_q.size()), 32'(base + 1));
        if (wr_q.size() >= 2) begin
            chk("mid_logged", 32'(wr_q[wr_q.size()-1]), 32'({2'd1, 8'hC3}));
            chk("mid_gap", 32'(wr_t[wr_t.size()-1] - wr_t[wr_t.size()-2]), 32'd42);
        end

`ifdef UART_ARB_LOCK_EN
        // Lock: requester 0 takes three bytes while 1 waits, then 1 after unlock
        req_data = 32'h0000_B2B1;
        base = wr_q.size();
        req_lock = 4'b0001;
        req_valid = 4'b0011;
        n = 0;
        while (wr_q.size() < base + 3 && n < 400) begin
            tick();
            n++;
        end
        req_lock = '0;
        while (wr_q.size() < base + 4 && n < 600) begin
            tick();
            n++;
        end
        req_valid = '0;
        chk("lock_count", 32'(wr_q.size()), 32'(base + 4));
        if (wr_q.size() >= base + 4) begin
            chk("lock_0", 32'(wr_q[base]),   32'({2'd0, 8'hB1}));
            chk("lock_1", 32'(wr_q[base+1]), 32'({2'd0, 8'hB1}));
            chk("lock_2", 32'(wr_q[base+2]), 32'({2'd0, 8'hB1}));
            chk("lock_3", 32'(wr_q[base+3]), 32'({2'd1, 8'hB2}));
        end
        wait_idle("lock_idle");
`endif

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
